// File: rtl/circle_pkg.sv
// Shared types and helpers for the midpoint circle rasteriser.
package circle_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StOct,
    StSpanSetup,
    StSpan,
    StUpdate,
    StDone
  } state_e;

  // Bit i describes octant point i: swap ox/oy, negate x offset, negate y offset.
  localparam logic [7:0] OctSwap = 8'b0110_0110;
  localparam logic [7:0] OctNegX = 8'b0011_1100;
  localparam logic [7:0] OctNegY = 8'b1111_0000;

  function automatic logic on_screen(input int x, input int y, input int x_max,
                                     input int y_max);
    return (x >= 0) && (x <= x_max) && (y >= 0) && (y <= y_max);
  endfunction

endpackage

// File: rtl/span_clamp.sv
// Clamps one horizontal span of a filled disc to the visible screen.
module span_clamp
  import circle_pkg::*;
#(
  parameter int unsigned X_W   = 8,
  parameter int unsigned ROW_W = 10,
  parameter int unsigned X_MAX = 159,
  parameter int unsigned Y_MAX = 119
) (
  input  logic signed [X_W+1:0]   i_centre,
  input  logic        [X_W-1:0]   i_half,
  input  logic signed [ROW_W-1:0] i_row,
  output logic        [X_W-1:0]   o_left,
  output logic        [X_W-1:0]   o_right,
  output logic                    o_valid
);

  localparam logic signed [X_W+2:0] XMaxS = (X_W + 3)'(X_MAX);

  logic signed [X_W+2:0] w_centre, w_half, w_left_raw, w_right_raw, w_left, w_right;

  always_comb begin
    w_centre    = $signed({i_centre[X_W+1], i_centre});
    w_half      = $signed({3'b000, i_half});
    w_left_raw  = w_centre - w_half;
    w_right_raw = w_centre + w_half;
    w_left      = (w_left_raw < 0) ? '0 : w_left_raw;
    w_right     = (w_right_raw > XMaxS) ? XMaxS : w_right_raw;
    // A span entirely right of the screen leaves left > right after clamping.
    o_valid     = on_screen(0, int'(i_row), int'(X_MAX), int'(Y_MAX)) && (w_left <= w_right);
    o_left      = w_left[X_W-1:0];
    o_right     = w_right[X_W-1:0];
  end

endmodule

// File: rtl/circle_engine.sv
// Midpoint circle rasteriser: outline or filled disc, clipped, one pixel write per cycle.
module circle_engine
  import circle_pkg::*;
#(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned X_MAX    = 159,
  parameter int unsigned Y_MAX    = 119,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [X_W-1:0]      i_centre_x,
  input  logic [Y_W-1:0]      i_centre_y,
  input  logic [X_W-1:0]      i_radius,
  input  logic [COLOUR_W-1:0] i_colour,
  input  logic                i_fill,
  output logic                o_done,
  output logic [X_W-1:0]      o_vga_x,
  output logic [Y_W-1:0]      o_vga_y,
  output logic [COLOUR_W-1:0] o_vga_colour,
  output logic                o_vga_plot
);

  // Wide enough that cy+ox never wraps back onto the screen.
  localparam int unsigned P_W = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int unsigned C_W = X_W + 3;
  localparam logic signed [C_W-1:0] CritOne = C_W'(1);
  localparam logic signed [X_W+1:0] OffOne  = (X_W + 2)'(1);

  state_e                r_state, w_state_d;
  logic [X_W-1:0]        r_cx, w_cx_d, r_ox, w_ox_d, r_oy, w_oy_d;
  logic [Y_W-1:0]        r_cy, w_cy_d;
  logic signed [C_W-1:0] r_crit, w_crit_d;
  logic [COLOUR_W-1:0]   r_colour, w_colour_d;
  logic                  r_fill, w_fill_d;
  logic [2:0]            r_oct, w_oct_d;
  logic [1:0]            r_span, w_span_d;
  logic [X_W-1:0]        r_sx, w_sx_d, r_sr, w_sr_d;
  logic [Y_W-1:0]        r_sy, w_sy_d;
  logic                  r_done, r_vga_plot;
  logic [X_W-1:0]        r_vga_x;
  logic [Y_W-1:0]        r_vga_y;
  logic [COLOUR_W-1:0]   r_vga_colour;

  // Span geometry for the current span index (used only in SPAN_SETUP).
  logic [X_W-1:0]        w_row_off, w_half, w_left, w_right;
  logic signed [P_W-1:0] w_row;
  logic signed [X_W+1:0] w_span_cx;
  logic                  w_span_ok;

  always_comb begin
    w_row_off = r_span[1] ? r_ox : r_oy;
    w_half    = r_span[1] ? r_oy : r_ox;
    w_span_cx = $signed({2'b00, r_cx});
    w_row     = r_span[0] ?
                $signed({{(P_W-Y_W){1'b0}}, r_cy}) - $signed({{(P_W-X_W){1'b0}}, w_row_off}) :
                $signed({{(P_W-Y_W){1'b0}}, r_cy}) + $signed({{(P_W-X_W){1'b0}}, w_row_off});
  end

  span_clamp #(
    .X_W  (X_W),
    .ROW_W(P_W),
    .X_MAX(X_MAX),
    .Y_MAX(Y_MAX)
  ) u_span_clamp (
    .i_centre(w_span_cx),
    .i_half  (w_half),
    .i_row   (w_row),
    .o_left  (w_left),
    .o_right (w_right),
    .o_valid (w_span_ok)
  );

  // Midpoint step.
  logic signed [X_W+1:0] w_ox_s, w_oy_n, w_ox_n;
  logic signed [C_W-1:0] w_step, w_crit_n;
  logic                  w_more;

  always_comb begin
    w_ox_s   = $signed({2'b00, r_ox});
    w_oy_n   = $signed({2'b00, r_oy}) + OffOne;
    w_ox_n   = (r_crit <= 0) ? w_ox_s : w_ox_s - OffOne;
    w_step   = (r_crit <= 0) ? $signed({w_oy_n[X_W+1], w_oy_n}) :
               $signed({w_oy_n[X_W+1], w_oy_n}) - $signed({w_ox_n[X_W+1], w_ox_n});
    w_crit_n = r_crit + (w_step <<< 1) + CritOne;
    w_more   = (w_oy_n <= w_ox_n);
  end

  always_comb begin
    w_state_d  = r_state;
    w_cx_d     = r_cx;
    w_cy_d     = r_cy;
    w_ox_d     = r_ox;
    w_oy_d     = r_oy;
    w_crit_d   = r_crit;
    w_colour_d = r_colour;
    w_fill_d   = r_fill;
    w_oct_d    = r_oct;
    w_span_d   = r_span;
    w_sx_d     = r_sx;
    w_sr_d     = r_sr;
    w_sy_d     = r_sy;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_cx_d     = i_centre_x;
          w_cy_d     = i_centre_y;
          w_ox_d     = i_radius;
          w_oy_d     = '0;
          w_crit_d   = CritOne - $signed({3'b000, i_radius});
          w_colour_d = i_colour;
          w_fill_d   = i_fill;
          w_oct_d    = '0;
          w_span_d   = '0;
          w_state_d  = i_fill ? StSpanSetup : StOct;
        end
      end
      StOct: begin
        if (r_oct == 3'd7) w_state_d = StUpdate;
        else               w_oct_d   = r_oct + 3'd1;
      end
      StSpanSetup: begin
        if (w_span_ok) begin
          w_state_d = StSpan;
          w_sx_d    = w_left;
          w_sr_d    = w_right;
          w_sy_d    = w_row[Y_W-1:0];
        end else if (r_span == 2'd3) begin
          w_state_d = StUpdate;
        end else begin
          w_span_d = r_span + 2'd1;
        end
      end
      StSpan: begin
        if (r_sx != r_sr) begin
          w_sx_d = r_sx + 1'b1;
        end else if (r_span == 2'd3) begin
          w_state_d = StUpdate;
        end else begin
          w_span_d  = r_span + 2'd1;
          w_state_d = StSpanSetup;
        end
      end
      StUpdate: begin
        w_oy_d    = w_oy_n[X_W-1:0];
        w_ox_d    = w_ox_n[X_W-1:0];
        w_crit_d  = w_crit_n;
        w_oct_d   = '0;
        w_span_d  = '0;
        w_state_d = !w_more ? StDone : (r_fill ? StSpanSetup : StOct);
      end
      StDone: begin
        if (!i_start) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Octant point for the upcoming cycle, so the registered outputs line up with the state.
  logic [X_W-1:0]        w_off_x, w_off_y;
  logic signed [P_W-1:0] w_cxs, w_cys, w_dxs, w_dys, w_pt_x, w_pt_y;
  logic                  w_pt_on;

  always_comb begin
    w_off_x = OctSwap[w_oct_d] ? w_oy_d : w_ox_d;
    w_off_y = OctSwap[w_oct_d] ? w_ox_d : w_oy_d;
    w_cxs   = $signed({{(P_W-X_W){1'b0}}, w_cx_d});
    w_cys   = $signed({{(P_W-Y_W){1'b0}}, w_cy_d});
    w_dxs   = $signed({{(P_W-X_W){1'b0}}, w_off_x});
    w_dys   = $signed({{(P_W-X_W){1'b0}}, w_off_y});
    w_pt_x  = OctNegX[w_oct_d] ? w_cxs - w_dxs : w_cxs + w_dxs;
    w_pt_y  = OctNegY[w_oct_d] ? w_cys - w_dys : w_cys + w_dys;
    w_pt_on = on_screen(int'(w_pt_x), int'(w_pt_y), int'(X_MAX), int'(Y_MAX));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cx         <= '0;
      r_cy         <= '0;
      r_ox         <= '0;
      r_oy         <= '0;
      r_crit       <= '0;
      r_colour     <= '0;
      r_fill       <= 1'b0;
      r_oct        <= '0;
      r_span       <= '0;
      r_sx         <= '0;
      r_sr         <= '0;
      r_sy         <= '0;
      r_done       <= 1'b0;
      r_vga_plot   <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
    end else begin
      r_state      <= w_state_d;
      r_cx         <= w_cx_d;
      r_cy         <= w_cy_d;
      r_ox         <= w_ox_d;
      r_oy         <= w_oy_d;
      r_crit       <= w_crit_d;
      r_colour     <= w_colour_d;
      r_fill       <= w_fill_d;
      r_oct        <= w_oct_d;
      r_span       <= w_span_d;
      r_sx         <= w_sx_d;
      r_sr         <= w_sr_d;
      r_sy         <= w_sy_d;
      r_done       <= (w_state_d == StDone);
      r_vga_plot   <= ((w_state_d == StOct) && w_pt_on) || (w_state_d == StSpan);
      r_vga_x      <= (w_state_d == StSpan) ? w_sx_d : w_pt_x[X_W-1:0];
      r_vga_y      <= (w_state_d == StSpan) ? w_sy_d : w_pt_y[Y_W-1:0];
      r_vga_colour <= w_colour_d;
    end
  end

  assign o_done       = r_done;
  assign o_vga_plot   = r_vga_plot;
  assign o_vga_x      = r_vga_x;
  assign o_vga_y      = r_vga_y;
  assign o_vga_colour = r_vga_colour;

endmodule

// File: tb/tb_circle_engine.sv
// Randomised bench for circle_engine against a cycle-list model of the midpoint algorithm.
module tb_circle_engine;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned X_MAX    = 159;
  localparam int unsigned Y_MAX    = 119;
  localparam int unsigned COLOUR_W = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [X_W-1:0]      centre_x;
  logic [Y_W-1:0]      centre_y;
  logic [X_W-1:0]      radius;
  logic [COLOUR_W-1:0] colour;
  logic                fill;
  logic                done;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  circle_engine #(
    .X_W     (X_W),
    .Y_W     (Y_W),
    .X_MAX   (X_MAX),
    .Y_MAX   (Y_MAX),
    .COLOUR_W(COLOUR_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_centre_x  (centre_x),
    .i_centre_y  (centre_y),
    .i_radius    (radius),
    .i_colour    (colour),
    .i_fill      (fill),
    .o_done      (done),
    .o_vga_x     (vga_x),
    .o_vga_y     (vga_y),
    .o_vga_colour(vga_colour),
    .o_vga_plot  (vga_plot)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  // One entry per active cycle after start: plot strobe and pixel.
  typedef struct {
    bit plot;
    int x;
    int y;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic void push_cyc(input bit p, input int x, input int y);
    cyc_t c;
    c.plot = p;
    c.x    = x;
    c.y    = y;
    exp_q.push_back(c);
  endfunction

  function automatic void build_model(input int cx, input int cy, input int r, input bit f);
    int ox, oy, crit, l, rr;
    int px[8];
    int py[8];
    int rows[4];
    int hw[4];
    exp_q.delete();
    ox   = r;
    oy   = 0;
    crit = 1 - r;
    do begin
      if (!f) begin
        px = '{cx + ox, cx + oy, cx - oy, cx - ox, cx - ox, cx - oy, cx + oy, cx + ox};
        py = '{cy + oy, cy + ox, cy + ox, cy + oy, cy - oy, cy - ox, cy - ox, cy - oy};
        for (int i = 0; i < 8; i++) begin
          push_cyc(px[i] >= 0 && px[i] <= int'(X_MAX) && py[i] >= 0 && py[i] <= int'(Y_MAX),
                   px[i], py[i]);
        end
      end else begin
        rows = '{cy + oy, cy - oy, cy + ox, cy - ox};
        hw   = '{ox, ox, oy, oy};
        for (int s = 0; s < 4; s++) begin
          push_cyc(1'b0, 0, 0);
          l  = (cx - hw[s] < 0) ? 0 : cx - hw[s];
          rr = (cx + hw[s] > int'(X_MAX)) ? int'(X_MAX) : cx + hw[s];
          if (rows[s] >= 0 && rows[s] <= int'(Y_MAX)) begin
            for (int x = l; x <= rr; x++) push_cyc(1'b1, x, rows[s]);
          end
        end
      end
      push_cyc(1'b0, 0, 0);
      oy++;
      if (crit <= 0) begin
        crit += 2 * oy + 1;
      end else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
  endfunction

  task automatic scramble_inputs();
    centre_x = X_W'($urandom_range(0, 255));
    centre_y = Y_W'($urandom_range(0, 127));
    radius   = X_W'($urandom_range(0, 255));
    colour   = COLOUR_W'($urandom_range(0, 7));
    fill     = 1'($urandom_range(0, 1));
  endtask

  // abort_at >= 0 stops (still busy) just before comparing that cycle.
  task automatic run_draw(input int cx, input int cy, input int r, input int col, input bit f,
                          input int abort_at);
    int n_plot_dut;
    int n_plot_exp;
    n_plot_dut = 0;
    n_plot_exp = 0;
    build_model(cx, cy, r, f);
    @(negedge clk);
    start    = 1'b1;
    centre_x = X_W'(cx);
    centre_y = Y_W'(cy);
    radius   = X_W'(r);
    colour   = COLOUR_W'(col);
    fill     = f;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (abort_at >= 0 && k == abort_at) return;
      check_val("plot", int'(vga_plot), int'(exp_q[k].plot));
      check_val("done_busy", int'(done), 0);
      if (exp_q[k].plot) begin
        n_plot_exp++;
        check_val("vga_x", int'(vga_x), exp_q[k].x);
        check_val("vga_y", int'(vga_y), exp_q[k].y);
        check_val("vga_colour", int'(vga_colour), col);
      end
      if (vga_plot) n_plot_dut++;
      scramble_inputs();
      @(posedge clk);
      @(negedge clk);
    end
    check_val("plot_count", n_plot_dut, n_plot_exp);
    check_val("done_rise", int'(done), 1);
    check_val("plot_in_done", int'(vga_plot), 0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_val("done_hold", int'(done), 1);
      check_val("no_retrigger", int'(vga_plot), 0);
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("done_fall", int'(done), 0);
    check_val("idle_plot", int'(vga_plot), 0);
    @(posedge clk);
    @(negedge clk);
    check_val("idle_done", int'(done), 0);
    check_val("idle_plot2", int'(vga_plot), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    centre_x = '0;
    centre_y = '0;
    radius   = '0;
    colour   = '0;
    fill     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_done", int'(done), 0);
    check_val("rst_plot", int'(vga_plot), 0);
    check_val("rst_x", int'(vga_x), 0);
    check_val("rst_y", int'(vga_y), 0);
    check_val("rst_colour", int'(vga_colour), 0);
    rst_n = 1'b1;

    run_draw(80, 60, 0, 5, 1'b0, -1);
    run_draw(80, 60, 1, 3, 1'b0, -1);
    run_draw(80, 60, 1, 6, 1'b1, -1);
    run_draw(0, 0, 5, 1, 1'b0, -1);
    run_draw(158, 118, 10, 2, 1'b1, -1);
    run_draw(250, 125, 7, 4, 1'b1, -1);

    for (int t = 0; t < 24; t++) begin
      run_draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 24)), int'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), -1);
    end

    // Abort a filled draw in the middle of its first span.
    run_draw(80, 60, 10, 4, 1'b1, 5);
    check_val("mid_span_plot", int'(vga_plot), 1);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("abort_plot", int'(vga_plot), 0);
    check_val("abort_done", int'(done), 0);
    check_val("abort_x", int'(vga_x), 0);
    check_val("abort_y", int'(vga_y), 0);
    check_val("abort_colour", int'(vga_colour), 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_val("post_abort_plot", int'(vga_plot), 0);
      check_val("post_abort_done", int'(done), 0);
    end
    run_draw(40, 30, 3, 7, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/circle_engine.md
# circle_engine

Parametrised circle rasteriser for the 160x120 VGA framebuffer path, the successor to the fixed-function shape drawers. It latches a centre, radius, colour and mode on a start/done handshake. It then runs the midpoint circle algorithm and emits one pixel write per cycle on the vga_x/vga_y/vga_colour/vga_plot bus, which feeds vga_adapter directly. Compared with the earlier drawers it adds:
- generic screen geometry;
- a filled mode;
- clipping, so no wrapped or off-screen coordinate is ever plotted.

## Interface
- X_W, 8, width of x coordinate and radius
- Y_W, 7, width of y coordinate
- X_MAX, 159, rightmost visible column
- Y_MAX, 119, bottom visible row
- COLOUR_W, 3, colour width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  request; sampled only in IDLE
- centre_x  in  X_W  circle centre column
- centre_y  in  Y_W  circle centre row
- radius  in  X_W  radius in pixels, 0 legal
- colour  in  COLOUR_W  pixel colour
- fill  in  1  0 = outline, 1 = filled disc
- done  out  1  drawing complete
- vga_x  out  X_W  pixel column
- vga_y  out  Y_W  pixel row
- vga_colour  out  COLOUR_W  pixel colour
- vga_plot  out  1  write strobe, one pixel per cycle

## Operation
- States: IDLE, OCT (outline plotting), SPAN_SETUP, SPAN (filled plotting), UPDATE, DONE.
- IDLE with start=1: latch centre_x, centre_y, radius, colour, fill. Init ox=radius, oy=0, crit=1-radius. Next state is OCT if fill=0, else SPAN_SETUP.
- Later input changes have no effect until the next IDLE.
- crit is signed, X_W+3 bits. Candidate coordinates are signed, X_W+2 / Y_W+2 bits.
- A pixel is on-screen iff 0<=x<=X_MAX and 0<=y<=Y_MAX.
- OCT: 8 cycles, octant index 0..7. Points in order:
  - (cx+ox,cy+oy), (cx+oy,cy+ox), (cx-oy,cy+ox), (cx-ox,cy+oy)
  - (cx-ox,cy-oy), (cx-oy,cy-ox), (cx+oy,cy-ox), (cx+ox,cy-oy)
  - vga_plot=1 only if the point is on-screen. Off-screen points still consume their cycle with vga_plot=0.
- SPAN_SETUP / SPAN: 4 spans per iteration, in row order cy+oy, cy-oy, cy+ox, cy-ox.
  - Half-widths are ox, ox, oy, oy respectively.
  - SPAN_SETUP costs 1 cycle with vga_plot=0. It clamps the left edge to 0 and the right edge to X_MAX.
  - If the row is off-screen, or the clamped left edge exceeds the clamped right edge, the span has no pixels and SPAN is skipped.
  - SPAN emits left..right, one pixel per cycle, vga_plot=1.
  - Duplicate pixels, e.g. rows drawn twice when oy=0, are plotted again.
- UPDATE: 1 cycle, vga_plot=0.
  - oy'=oy+1.
  - If crit<=0: crit'=crit+2*oy'+1.
  - Else: ox'=ox-1 and crit'=crit+2*(oy'-ox')+1.
  - Then if oy'<=ox', start the next iteration (OCT or SPAN_SETUP). Otherwise go to DONE.
- DONE: done=1 while start=1. Return to IDLE the cycle after start=0. A held start does not retrigger.
- Reset:
  - done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, state IDLE.
  - Reset mid-draw aborts on the next edge with no further plots.

## Timing
- All outputs are registered. vga_x/vga_y/vga_colour are valid in any cycle with vga_plot=1.
- First OCT or SPAN_SETUP cycle: 1 cycle after start is sampled.
- Outline latency: 9 cycles per iteration (8 OCT + 1 UPDATE), independent of clipping.
- Filled latency: per iteration, 4 setup cycles + clamped on-screen span pixels + 1 UPDATE.
- done rises the cycle after the final UPDATE.
- vga_plot is never asserted in IDLE, UPDATE, SPAN_SETUP or DONE.

## Structure
- Shared package circle_pkg:
  - state enum;
  - octant sign/swap constants for the eight points;
  - helper function on_screen(x, y) parametrised by X_MAX/Y_MAX.
- Sub-module span_clamp (combinational): takes signed centre, half-width and row; produces clamped left, clamped right and a valid flag. Used only by SPAN_SETUP.
- The top integration instantiates circle_engine in place of the earlier drawer, with radius driven from switches.

## Test plan
- Outline, (80,60), r=0 → 8 plots of (80,60), then 1 UPDATE cycle; done at cycle 10 after start.
- Outline, (80,60), r=1 → 16 plots, 18 active cycles:
  - iteration 1: (81,60), (80,61), (80,61), (79,60), (79,60), (80,59), (80,59), (81,60);
  - iteration 2: diagonals (81,61), (79,61), (79,59), (81,59), each plotted twice.
- Filled, (80,60), r=1 → iteration 1: rows 60, 60 plot x=79..81; rows 61, 59 plot x=80. Iteration 2: rows 61, 59, 61, 59 plot x=79..81. Total 30 cycles, 20 plots.
- Outline, (0,0), r=5 → no plot with x or y outside the screen, i.e. no wrapped 255/127 values. Cycle count equals the unclipped count.
- Filled, (158,118), r=10 → every span is clamped: no plot exceeds (159,119), and rows >119 produce setup cycles only.
- Handshake and reset:
  - holding start after done → no redraw; deasserting start → IDLE next cycle, done=0;
  - rst_n=0 mid-SPAN → next cycle vga_plot=0, done=0, state IDLE.
